// File: rtl/core_pkg.sv
// Shared core memory-path types: requester identity and the muxed RAM command.
// Widths are fixed here so the struct stays packed and synthesizable.
package core_pkg;

    localparam int CORE_ADDR_W = 32;
    localparam int CORE_DATA_W = 32;
    localparam int CORE_BE_W   = CORE_DATA_W / 8;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } mem_port_e;

    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
        logic [CORE_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals around the memory arbiter.
// master is the arbiter's view; slave is the core/RAM side.
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [DATA_W-1:0]   if_rdata;

    logic                ls_req;
    logic                ls_we;
    logic [ADDR_W-1:0]   ls_addr;
    logic [DATA_W-1:0]   ls_wdata;
    logic [DATA_W/8-1:0] ls_be;
    logic                ls_gnt;
    logic                ls_rvalid;
    logic [DATA_W-1:0]   ls_rdata;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

endinterface

// File: rtl/core_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; gnt is one-hot or zero and only nonzero when en.
// The pointer names the side that wins a tie and moves past each winner.
module rr_arb2
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    mem_port_e ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[PORT_IF] && req[PORT_LS])
                gnt[ptr] = 1'b1;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= PORT_LS;
        else if (en && (gnt != 2'b00))
            ptr <= gnt[PORT_LS] ? PORT_IF : PORT_LS;
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares the single fixed-latency RAM port between fetch and load/store.
// One access in flight; cnt counts down to the response cycle, in which a new grant may issue.
module core_mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W  = CORE_ADDR_W,
    parameter int DATA_W  = CORE_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    core_mem_arbiter_if.master bus
);

    localparam int          CW  = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt;
    mem_port_e     owner;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          open;
    logic          resp;
    mem_req_t      if_cmd;
    mem_req_t      ls_cmd;
    mem_req_t      cmd;

    // Reset gates grants and responses combinationally so nothing leaks while it is held.
    assign open = (cnt <= ONE) && !reset;
    assign resp = (cnt == ONE) && !reset;

    assign req[PORT_IF] = bus.if_req;
    assign req[PORT_LS] = bus.ls_req;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (open),
        .gnt   (gnt)
    );

    assign if_cmd = '{we: 1'b0, addr: bus.if_addr, wdata: '0, be: '1};
    assign ls_cmd = '{we: bus.ls_we, addr: bus.ls_addr, wdata: bus.ls_wdata, be: bus.ls_be};
    assign cmd    = gnt[PORT_LS] ? ls_cmd : if_cmd;

    assign bus.if_gnt    = gnt[PORT_IF];
    assign bus.ls_gnt    = gnt[PORT_LS];
    assign bus.mem_req   = gnt[PORT_IF] | gnt[PORT_LS];
    assign bus.mem_we    = cmd.we;
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.mem_be    = cmd.be;

    // The response belongs to the registered owner even when a new grant issues this cycle.
    assign bus.if_rvalid = resp && (owner == PORT_IF);
    assign bus.ls_rvalid = resp && (owner == PORT_LS);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            owner <= PORT_IF;
        end else if (bus.mem_req) begin
            cnt   <= LAT;
            owner <= gnt[PORT_LS] ? PORT_LS : PORT_IF;
        end else if (cnt != '0) begin
            cnt   <= cnt - ONE;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed + randomized checks of core_mem_arbiter against a transaction-level model
// that tracks the response due time, tie-break favourite and expected RAM contents.
module tb_core_mem_arbiter;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_mem_arbiter_if b2 ();
    core_mem_arbiter_if b1 ();

    core_mem_arbiter #(.MEM_LAT(2)) dut2 (.clk(clk), .reset(rst), .bus(b2));
    core_mem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] init_word(logic [7:0] i);
        if (i == 8'd4)  return 32'hDEADBEEF;
        if (i == 8'd16) return 32'h0;
        return {i, ~i, i ^ 8'h5A, i + 8'd3};
    endfunction

    function automatic logic [31:0] be_mask(logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // RAM models: contents = init_word ^ ramx, read data delayed MEM_LAT cycles.
    logic [31:0] ramx [256] = '{default: 32'h0};
    logic [31:0] p0, p1, q1;

    function automatic logic [31:0] ram_rd(logic [7:0] i);
        return init_word(i) ^ ramx[i];
    endfunction

    always @(posedge clk) begin
        if (b2.mem_req) begin
            p0 <= ram_rd(b2.mem_addr[9:2]);
            if (b2.mem_we)
                ramx[b2.mem_addr[9:2]] <= ramx[b2.mem_addr[9:2]]
                    ^ ((ram_rd(b2.mem_addr[9:2]) ^ b2.mem_wdata) & be_mask(b2.mem_be));
        end else begin
            p0 <= 32'hBAADF00D;
        end
        p1 <= p0;
        q1 <= b1.mem_req ? init_word(b1.mem_addr[9:2]) : 32'hBAADF00D;
    end
    assign b2.mem_rdata = p1;
    assign b1.mem_rdata = q1;

    // Reference model state
    logic [31:0] refmem [256];
    int          cyc = 0;
    bit          pend = 0;
    int          resp_cyc = 0;
    mem_port_e   m_owner = PORT_IF;
    mem_port_e   fav = PORT_LS;
    logic [31:0] resp_data = '0;
    bit          resp_wr = 0;
    logic        obs_ls_gnt = 1'b0;
    logic [31:0] last_ls_rd = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] raddr();
        logic [7:0] r = 8'($urandom_range(0, 255));
        return {22'b0, r, 2'b00};
    endfunction

    task automatic step(bit autodrop, bit rnd);
        bit free;
        int win;
        bit rv_if, rv_ls;
        logic [7:0] idx;
        if (rnd) begin
            if (!b2.if_req && $urandom_range(0, 2) != 0) begin
                b2.if_req = 1'b1; b2.if_addr = raddr();
            end
            if (!b2.ls_req && $urandom_range(0, 2) != 0) begin
                b2.ls_req = 1'b1; b2.ls_we = 1'($urandom_range(0, 1));
                b2.ls_addr = raddr(); b2.ls_wdata = $urandom();
                b2.ls_be = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        free = !pend || (cyc == resp_cyc);
        win = -1;
        if (!rst && free) begin
            if (b2.if_req && b2.ls_req) win = (fav == PORT_LS) ? 1 : 0;
            else if (b2.ls_req)         win = 1;
            else if (b2.if_req)         win = 0;
        end
        chk("if_gnt", b2.if_gnt, 32'(win == 0));
        chk("ls_gnt", b2.ls_gnt, 32'(win == 1));
        chk("mem_req", b2.mem_req, 32'(win >= 0));
        obs_ls_gnt = b2.ls_gnt;
        if (win == 0) begin
            chk("if_mem_addr", b2.mem_addr, b2.if_addr);
            chk("if_mem_we", b2.mem_we, 0);
            chk("if_mem_be", b2.mem_be, 32'hF);
            chk("if_mem_wdata", b2.mem_wdata, 0);
        end else if (win == 1) begin
            chk("ls_mem_addr", b2.mem_addr, b2.ls_addr);
            chk("ls_mem_we", b2.mem_we, b2.ls_we);
            chk("ls_mem_be", b2.mem_be, b2.ls_be);
            chk("ls_mem_wdata", b2.mem_wdata, b2.ls_wdata);
        end
        rv_if = !rst && pend && (cyc == resp_cyc) && (m_owner == PORT_IF);
        rv_ls = !rst && pend && (cyc == resp_cyc) && (m_owner == PORT_LS);
        chk("if_rvalid", b2.if_rvalid, 32'(rv_if));
        chk("ls_rvalid", b2.ls_rvalid, 32'(rv_ls));
        if (rv_if) chk("if_rdata", b2.if_rdata, resp_data);
        if (rv_ls && !resp_wr) begin
            chk("ls_rdata", b2.ls_rdata, resp_data);
            last_ls_rd = b2.ls_rdata;
        end
        if (rst) begin
            pend = 0;
            fav  = PORT_LS;
        end else begin
            if (pend && cyc == resp_cyc) pend = 0;
            if (win >= 0) begin
                idx       = (win == 1) ? b2.ls_addr[9:2] : b2.if_addr[9:2];
                pend      = 1;
                resp_cyc  = cyc + 2;
                m_owner   = (win == 1) ? PORT_LS : PORT_IF;
                resp_data = refmem[idx];
                resp_wr   = (win == 1) && b2.ls_we;
                if (resp_wr)
                    refmem[idx] = (refmem[idx] & ~be_mask(b2.ls_be)) | (b2.ls_wdata & be_mask(b2.ls_be));
                fav = (win == 1) ? PORT_IF : PORT_LS;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (autodrop && win == 0) b2.if_req = 1'b0;
        if (autodrop && win == 1) b2.ls_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refmem[i] = init_word(8'(i));
        b2.if_req = 0; b2.if_addr = '0;
        b2.ls_req = 0; b2.ls_we = 0; b2.ls_addr = '0; b2.ls_wdata = '0; b2.ls_be = '0;
        b1.if_req = 0; b1.if_addr = '0;
        b1.ls_req = 0; b1.ls_we = 0; b1.ls_addr = '0; b1.ls_wdata = '0; b1.ls_be = '0;
        rst = 1'b1;
        step(0, 0); step(0, 0);
        rst = 1'b0;

        // single fetch of 0x10
        b2.if_req = 1; b2.if_addr = 32'h10;
        repeat (4) step(1, 0);

        // sustained contention alternates LS, IF, LS, IF
        b2.if_req = 1; b2.if_addr = 32'h20;
        b2.ls_req = 1; b2.ls_we = 0; b2.ls_addr = 32'h80; b2.ls_be = 4'hF;
        repeat (8) step(0, 0);
        b2.if_req = 0; b2.ls_req = 0;
        repeat (3) step(0, 0);

        // partial write then readback
        b2.ls_req = 1; b2.ls_we = 1; b2.ls_addr = 32'h40; b2.ls_wdata = 32'h12345678; b2.ls_be = 4'b0011;
        repeat (3) step(1, 0);
        b2.ls_req = 1; b2.ls_we = 0; b2.ls_addr = 32'h40; b2.ls_be = 4'hF;
        repeat (3) step(1, 0);
        chk("t3_readback", last_ls_rd, 32'h00005678);

        // LS arriving during IF's WAIT is held off until RESP
        b2.if_req = 1; b2.if_addr = 32'h30;
        step(1, 0);
        b2.ls_req = 1; b2.ls_we = 0; b2.ls_addr = 32'h44;
        step(1, 0);
        chk("t5_no_gnt_wait", obs_ls_gnt, 0);
        step(1, 0);
        chk("t5_gnt_resp", obs_ls_gnt, 1);
        repeat (3) step(1, 0);

        // reset in WAIT drops the response and restores LS priority
        b2.if_req = 1; b2.if_addr = 32'h50;
        step(1, 0);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        b2.if_req = 1; b2.ls_req = 1; b2.ls_addr = 32'h54;
        step(1, 0);
        chk("t6_ls_first", obs_ls_gnt, 1);
        repeat (5) step(1, 0);

        repeat (400) step(1, 1);
        rst = 1'b0;
        repeat (8) step(1, 0);

        // MEM_LAT=1: one fetch per cycle, data in order
        for (int k = 0; k < 10; k++) begin
            b1.if_req = 1; b1.if_addr = 32'h100 + 32'(4 * k);
            @(negedge clk);
            chk("t4_gnt", b1.if_gnt, 1);
            chk("t4_addr", b1.mem_addr, 32'h100 + 32'(4 * k));
            chk("t4_rvalid", b1.if_rvalid, 32'(k > 0));
            chk("t4_ls_rvalid", b1.ls_rvalid, 0);
            if (k > 0) chk("t4_rdata", b1.if_rdata, init_word(8'(64 + k - 1)));
            @(posedge clk);
            #1;
        end
        b1.if_req = 0;
        @(negedge clk);
        chk("t4_last_rvalid", b1.if_rvalid, 1);
        chk("t4_last_rdata", b1.if_rdata, init_word(8'(73)));
        chk("t4_idle_gnt", b1.if_gnt, 0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
